// File: rtl/adat_pkg.sv
// Shared definitions for the ADAT frame generator and checker.
package adat_pkg;

  localparam int          PAT_LEN     = 28;
  localparam logic [27:0] DEF_PATTERN = 28'h6CC1555;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

endpackage

// File: rtl/adat_sat_cntr.sv
// Saturating up-counter with synchronous clear that wins over increment.
module adat_sat_cntr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adat_check.sv
// ADAT reference-pattern checker: hunts for frame alignment, verifies it
// over further frames, then counts bit errors while locked.
module adat_check
  import adat_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PATTERN  = DEF_PATTERN,
  parameter int                 LOSS_THR = 4,
  parameter int                 VERIFY_N = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adat_be,
  input  logic        data_valid,
  input  logic        clear,
  output logic        locked,
  output logic        bit_err,
  output logic [15:0] err_cnt,
  output logic [23:0] bit_cnt
);

  localparam logic [4:0] PHASE_LAST = 5'(PAT_LEN - 1);

  state_e               state_q, state_d;
  logic [PAT_LEN-1:0]   win_q, win_d, win_next;
  logic [4:0]           phase_q, phase_d;
  logic [7:0]           match_q, match_d;
  logic [7:0]           ferr_q, ferr_d, ferr_next;
  logic                 bit_err_q, bit_err_d;
  logic                 pat_hit, exp_bit, mismatch;
  logic                 inc_bit, inc_err;

  assign win_next = {win_q[PAT_LEN-2:0], adat_be};
  assign pat_hit  = (win_next == PATTERN);
  assign exp_bit  = PATTERN[PHASE_LAST - phase_q];
  assign mismatch = (adat_be != exp_bit);
  assign ferr_next = ferr_q + {7'd0, mismatch};

  // Next-state, alignment tracking and per-bit statistics strobes.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    phase_d   = phase_q;
    match_d   = match_q;
    ferr_d    = ferr_q;
    bit_err_d = 1'b0;
    inc_bit   = 1'b0;
    inc_err   = 1'b0;

    if (data_valid) begin
      win_d = win_next;
      unique case (state_q)
        HUNT: begin
          if (pat_hit) begin
            state_d = VERIFY;
            phase_d = '0;
            match_d = 8'd1;
          end
        end
        VERIFY: begin
          if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            if (!pat_hit) begin
              state_d = HUNT;
              match_d = '0;
            end else if (match_q == 8'(VERIFY_N)) begin
              state_d = LOCK;
              match_d = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + 5'd1;
          end
        end
        LOCK: begin
          inc_bit   = 1'b1;
          inc_err   = mismatch;
          bit_err_d = mismatch;
          if (ferr_next == 8'(LOSS_THR)) begin
            state_d = HUNT;
            phase_d = '0;
            ferr_d  = '0;
          end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            ferr_d  = '0;
          end else begin
            phase_d = phase_q + 5'd1;
            ferr_d  = ferr_next;
          end
        end
        default: begin
          state_d = HUNT;
          phase_d = '0;
          match_d = '0;
          ferr_d  = '0;
        end
      endcase
    end
  end

  // State, window, phase and frame-error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      win_q     <= '0;
      phase_q   <= '0;
      match_q   <= '0;
      ferr_q    <= '0;
      bit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      phase_q   <= phase_d;
      match_q   <= match_d;
      ferr_q    <= ferr_d;
      bit_err_q <= bit_err_d;
    end
  end

  adat_sat_cntr #(.W(16)) u_err_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .inc_i (inc_err),
    .clr_i (clear),
    .cnt_o (err_cnt)
  );

  adat_sat_cntr #(.W(24)) u_bit_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .inc_i (inc_bit),
    .clr_i (clear),
    .cnt_o (bit_cnt)
  );

  assign locked  = (state_q == LOCK);
  assign bit_err = bit_err_q;

endmodule

// File: tb/tb_adat_check.sv
// Self-checking bench for adat_check against a behavioural reference model.
module tb_adat_check;
  import adat_pkg::*;

  localparam logic [27:0] PAT = DEF_PATTERN;
  localparam int LOSS_THR = 4;
  localparam int VERIFY_N = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        adat_be;
  logic        data_valid;
  logic        clear;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_cnt;
  logic [23:0] bit_cnt;

  adat_check #(.PATTERN(PAT), .LOSS_THR(LOSS_THR), .VERIFY_N(VERIFY_N)) dut (
    .clock      (clock),
    .reset      (reset),
    .adat_be    (adat_be),
    .data_valid (data_valid),
    .clear      (clear),
    .locked     (locked),
    .bit_err    (bit_err),
    .err_cnt    (err_cnt),
    .bit_cnt    (bit_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Stream position, the bits seen so far, and the three-mode tracker.
  typedef enum int {M_HUNT, M_VERIFY, M_LOCK} mmode_e;
  bit     pat_bits[28];
  bit     m_hist[$];
  mmode_e m_mode;
  int     m_phase, m_conf, m_ferr, m_errs, m_bits;
  bit     m_berr;
  int     strm_idx;
  int     rise_idx, fall_idx;

  function automatic bit stream_bit(input int idx);
    return pat_bits[idx % 28];
  endfunction

  task automatic m_reset();
    m_hist.delete();
    m_mode = M_HUNT; m_phase = 0; m_conf = 0; m_ferr = 0;
    m_errs = 0; m_bits = 0; m_berr = 0;
  endtask

  task automatic m_step(input bit b, input bit clr);
    bit aligned;
    m_hist.push_back(b);
    if (m_hist.size() > 28) void'(m_hist.pop_front());
    aligned = (m_hist.size() == 28);
    for (int i = 0; i < m_hist.size(); i++)
      if (m_hist[i] != pat_bits[i]) aligned = 0;
    m_berr = 0;
    case (m_mode)
      M_HUNT: if (aligned) begin m_mode = M_VERIFY; m_phase = 0; m_conf = 0; end
      M_VERIFY: begin
        if (m_phase == 27) begin
          if (!aligned) m_mode = M_HUNT;
          else begin
            m_conf++;
            if (m_conf == VERIFY_N) m_mode = M_LOCK;
          end
          m_phase = 0;
        end else m_phase++;
      end
      M_LOCK: begin
        if (m_bits < 24'hFFFFFF) m_bits++;
        if (b != pat_bits[m_phase]) begin
          m_berr = 1;
          if (m_errs < 16'hFFFF) m_errs++;
          m_ferr++;
        end
        if (m_ferr == LOSS_THR) begin
          m_mode = M_HUNT; m_phase = 0; m_ferr = 0;
        end else if (m_phase == 27) begin
          m_phase = 0; m_ferr = 0;
        end else m_phase++;
      end
      default: m_mode = M_HUNT;
    endcase
    if (clr) begin m_errs = 0; m_bits = 0; end
  endtask

  // ---------------- stimulus helpers ----------------
  // Entered and left at a falling edge.
  task automatic send(input bit b, input bit clr, input int gap);
    logic prev_locked;
    prev_locked = locked;
    data_valid = 1'b1; adat_be = b; clear = clr;
    @(negedge clock);
    data_valid = 1'b0; clear = 1'b0;
    m_step(b, clr);
    check(32'(locked),  32'(m_mode == M_LOCK), "locked");
    check(32'(bit_err), 32'(m_berr),           "bit_err");
    check(32'(err_cnt), 32'(m_errs),           "err_cnt");
    check(32'(bit_cnt), 32'(m_bits),           "bit_cnt");
    if (!prev_locked && locked) rise_idx = strm_idx;
    if (prev_locked && !locked) fall_idx = strm_idx;
    strm_idx++;
    if (gap > 0) begin
      @(negedge clock);
      check(32'(bit_err), 32'd0, "bit_err_width");
      repeat (gap - 1) @(negedge clock);
    end
  endtask

  // One 28-bit frame from the current stream position; err_mask bit p
  // inverts the bit at frame phase p, clr_phase asserts clear with that bit.
  task automatic send_frame(input logic [27:0] err_mask, input int gap, input int clr_phase);
    for (int p = 0; p < 28; p++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      send(stream_bit(strm_idx) ^ err_mask[p], (p == clr_phase), g);
    end
  endtask

  initial begin
    int start_idx;
    int budget;
    for (int i = 0; i < 28; i++) pat_bits[i] = PAT[27 - i];
    reset = 1'b1; data_valid = 1'b0; adat_be = 1'b0; clear = 1'b0;
    strm_idx = 0; rise_idx = -1; fall_idx = -1;
    m_reset();

    // Reset state.
    #12;
    check(32'(locked),  32'd0, "rst_locked");
    check(32'(bit_err), 32'd0, "rst_bit_err");
    check(32'(err_cnt), 32'd0, "rst_err_cnt");
    check(32'(bit_cnt), 32'd0, "rst_bit_cnt");
    check(32'(dut.state_q), 32'(HUNT), "rst_state");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Three clean frames, one valid every four clocks: lock on valid 84.
    repeat (3) send_frame(28'd0, 3, -1);
    check(32'(rise_idx + 1), 32'd84, "lock_valid_count");
    check(32'(err_cnt), 32'd0, "lock_err_cnt");

    // Single inverted bit at phase 5.
    send_frame(28'd1 << 5, 3, -1);
    check(32'(err_cnt), 32'd1, "single_err_cnt");
    check(32'(locked), 32'd1, "single_locked");
    check(32'(bit_cnt), 32'(strm_idx - rise_idx - 1), "single_bit_cnt");

    // Clear without a valid.
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check(32'(err_cnt), 32'd0, "clear_err_cnt");
    check(32'(bit_cnt), 32'd0, "clear_bit_cnt");
    m_errs = 0; m_bits = 0;

    // Three errors at a frame end plus three at the next start: no loss.
    fall_idx = -1;
    send_frame(28'h7 << 25, 1, -1);
    send_frame(28'h7, 0, -1);
    check(32'(err_cnt), 32'd6, "straddle_err_cnt");
    check(32'(locked), 32'd1, "straddle_locked");
    check(32'(fall_idx), 32'hFFFFFFFF, "straddle_no_fall");

    // Four errors within one frame: lock lost on the fourth, then relock.
    start_idx = strm_idx;
    send_frame((28'd1 << 3) | (28'd1 << 9) | (28'd1 << 14) | (28'd1 << 20), 2, -1);
    check(32'(fall_idx - start_idx), 32'd20, "loss_phase");
    start_idx = strm_idx;
    budget = 6;
    while (!locked && budget > 0) begin
      send_frame(28'd0, -1, -1);
      budget--;
    end
    check(32'(locked), 32'd1, "relock_reached");
    check(32'((rise_idx - start_idx + 1) >= 56 && (rise_idx - start_idx + 1) <= 84), 32'd1,
          "relock_window");

    // Saturation: error together with clear zeroes; error alone holds FFFF.
    force dut.u_err_cnt.cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.u_err_cnt.cnt_q;
    m_errs = 16'hFFFF;
    check(32'(err_cnt), 32'hFFFF, "forced_err_cnt");
    send_frame(28'd1, 1, 0);
    check(32'(err_cnt), 32'd0, "sat_clear_err_cnt");
    check(32'(bit_cnt), 32'd27, "sat_clear_bit_cnt");
    force dut.u_err_cnt.cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.u_err_cnt.cnt_q;
    m_errs = 16'hFFFF;
    send_frame(28'd1, 1, -1);
    check(32'(err_cnt), 32'hFFFF, "sat_hold_err_cnt");

    // Random error masks, gaps and clears against the model.
    for (int f = 0; f < 12; f++) begin
      logic [27:0] mask;
      int clr_p;
      mask = '0;
      for (int p = 0; p < 28; p++) mask[p] = ($urandom_range(0, 9) == 0);
      clr_p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 27)) : -1;
      send_frame(mask, -1, clr_p);
    end

    // Rotated stream with reset during VERIFY, then reacquire.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    strm_idx = 13;
    for (int k = 0; k < 60; k++) send(stream_bit(strm_idx), 1'b0, 1);
    check(32'(dut.state_q), 32'(VERIFY), "offset_in_verify");
    #2 reset = 1'b1;
    #1;
    check(32'(locked), 32'd0, "midreset_locked");
    check(32'(dut.state_q), 32'(HUNT), "midreset_state");
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    rise_idx = -1;
    budget = 200;
    while (!locked && budget > 0) begin
      send(stream_bit(strm_idx), 1'b0, 1);
      budget--;
    end
    check(32'(locked), 32'd1, "offset_relock");
    check(32'(rise_idx % 28), 32'd27, "offset_boundary");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
